iob_be_ram_ctrl: RTL

Parametrised IOb native back-end memory slave that serves a cache back-end port. It generalises the fixed single-cycle RAM-plus-rvalid-register arrangement with the following:
- configurable data and address width
- byte-enable writes
- configurable read latency (1..4)
- a programmable wait-state FSM that exercises ready back-pressure

It sits directly below iob_cache_iob as its be_* target in simulation and FPGA builds.

---
 rtl/iob_be_ram_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/iob_be_ram_ctrl.sv
// iob_be_ram_ctrl: IOb native back-end RAM slave with byte-enable writes,
// configurable read latency and a wait-state FSM that throttles ready.
module iob_be_ram_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1,
  parameter int WAIT_CYC = 0
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_rvalid_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int CNT_W = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

  if (READ_LAT < 1 || READ_LAT > 4 || DATA_W % 8 != 0) begin : g_bad_param
    $error("iob_be_ram_ctrl: READ_LAT must be 1..4 and DATA_W a multiple of 8");
  end

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^iob_addr_i[OFF_W-1:0];
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [2**WA_W];
  logic [READ_LAT-1:0] v_q;
  logic [DATA_W-1:0] d_q [READ_LAT];
  logic [WA_W-1:0]   wa;
  logic              acc, wr_acc, rd_acc;

  assign wa          = iob_addr_i[ADDR_W-1:OFF_W];
  assign iob_ready_o = (WAIT_CYC == 0) || (state_q == S_ACK);
  assign acc         = iob_valid_i & iob_ready_o & cke_i;
  assign wr_acc      = acc & (|iob_wstrb_i);
  assign rd_acc      = acc & ~(|iob_wstrb_i);

  // Dropping valid before acceptance always returns to IDLE, so nothing is half-accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (WAIT_CYC != 0)
      case (state_q)
        S_IDLE: if (iob_valid_i) begin
          state_d = WAIT_CYC == 1 ? S_ACK : S_WAIT;
          cnt_d   = CNT_INIT;
        end
        S_WAIT: begin
          state_d = !iob_valid_i ? S_IDLE : cnt_q == '0 ? S_ACK : S_WAIT;
          cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
  end

  always_ff @(posedge clk_i)
    if (wr_acc)
      for (int b = 0; b < NB; b++)
        if (iob_wstrb_i[b]) mem_q[wa][b*8 +: 8] <= iob_wdata_i[b*8 +: 8];

  // Each data stage loads only behind a valid bit, so the last stage holds the previous result.
  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) d_q[i] <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q[0]  <= rd_acc;
      if (rd_acc) d_q[0] <= mem_q[wa];
      for (int i = 1; i < READ_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end

  assign iob_rvalid_o = v_q[READ_LAT-1];
  assign iob_rdata_o  = d_q[READ_LAT-1];
endmodule
